// File: rtl/i2c_slave_write_rx.sv
// i2c_slave_write_rx
// I2C target receiver for write transfers. It oversamples SCL/SDA on the
// system clock, detects START/STOP, matches a 7-bit address, ACKs by pulling
// SDA low through an open-drain enable and hands each received byte out on a
// one-cycle valid strobe. Read requests and foreign addresses are NACKed.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   scl        in   I2C clock line as seen on the bus
//   sda        in   I2C data line as seen on the bus (wired-AND value)
//   sda_oe     out  1 = pull SDA low (ACK), 0 = release
//   data_out   out  last received data byte
//   data_valid out  one-cycle pulse when data_out is updated
//   addressed  out  high from address ACK until STOP or repeated START
//   start_det  out  one-cycle pulse on START / repeated START
//   stop_det   out  one-cycle pulse on STOP
module i2c_slave_write_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_sda_oe;
  logic       w_sda_oe_nxt;
  logic [7:0] r_data_out;
  logic [7:0] w_data_out_nxt;
  logic       r_data_valid;
  logic       w_data_valid_nxt;
  logic       r_addressed;
  logic       w_addressed_nxt;
  logic       r_start_det;
  logic       w_start_det_nxt;
  logic       r_stop_det;
  logic       w_stop_det_nxt;

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_shift_in;

  // Both bus lines go through identical synchroniser chains so their relative
  // ordering is preserved. Flops reset to 1 so a reset never looks like a
  // START/STOP or an SCL edge on an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  // SDA may only change while SCL is low, so an SDA edge with SCL steady
  // high on both samples is a bus condition rather than data.
  assign w_start    = r_sda_d & ~w_sda_s & w_scl_s & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda_s & w_scl_s & r_scl_d;
  assign w_shift_in = {r_shift[6:0], w_sda_s};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions. START/STOP override everything else,
  // which also suppresses any data_valid that would otherwise coincide.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_sda_oe_nxt     = r_sda_oe;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_addressed_nxt  = r_addressed;
    w_start_det_nxt  = 1'b0;
    w_stop_det_nxt   = 1'b0;

    if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_cnt_nxt       = 3'd0;
      w_addressed_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
      w_start_det_nxt = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_addressed_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
      w_stop_det_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if ((w_shift_in[7:1] == SLAVE_ADDR) && !w_shift_in[0]) begin
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end
          end
        end
        S_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_data_out_nxt   = w_shift_in;
              w_data_valid_nxt = 1'b1;
              w_state_nxt      = S_DATA_ACK;
            end
          end
        end
        // The first fall ends the 8th clock and starts the ACK; the second
        // fall ends the 9th clock. sda_oe itself tells which fall this is.
        // The bit counter has already wrapped to 0 for the next byte.
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt    = 1'b0;
              w_addressed_nxt = 1'b1;
              w_state_nxt     = S_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= 8'h00;
      r_cnt        <= 3'd0;
      r_sda_oe     <= 1'b0;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_addressed  <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_addressed  <= w_addressed_nxt;
      r_start_det  <= w_start_det_nxt;
      r_stop_det   <= w_stop_det_nxt;
    end
  end

  assign sda_oe     = r_sda_oe;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign addressed  = r_addressed;
  assign start_det  = r_start_det;
  assign stop_det   = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_write_rx.sv
// tb_i2c_slave_write_rx
// Drives an I2C master onto a wired-AND SDA net shared with the target,
// pushes every byte the target should accept into a scoreboard queue and
// pops/compares it whenever data_valid pulses.
module tb_i2c_slave_write_rx;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda;
  logic       sda_oe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addressed;
  logic       start_det;
  logic       stop_det;

  int checks = 0;
  int errors = 0;
  int nStart = 0;
  int nStop  = 0;
  int nValid = 0;
  logic [7:0] expQ[$];

  i2c_slave_write_rx #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_oe    (sda_oe),
    .data_out  (data_out),
    .data_valid(data_valid),
    .addressed (addressed),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain bus: either side pulling low wins.
  assign sda = sda_m & ~sda_oe;

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a transfer never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: counts strobes and scores each delivered byte.
  always @(negedge clk) begin
    if (rst) begin
      if (start_det) nStart++;
      if (stop_det)  nStop++;
      if (data_valid) begin
        nValid++;
        if (expQ.size() > 0) checkOutput("data_out", {24'h0, data_out}, {24'h0, expQ.pop_front()});
        else checkOutput("spurious_valid", {31'h0, data_valid}, 32'h0);
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic busStart();
    sda_m = 1'b1;
    waitClk(4);
    scl = 1'b1;
    waitClk(8);
    sda_m = 1'b0;
    waitClk(8);
    scl = 1'b0;
    waitClk(4);
  endtask

  task automatic busStop();
    sda_m = 1'b0;
    waitClk(4);
    scl = 1'b1;
    waitClk(8);
    sda_m = 1'b1;
    waitClk(8);
  endtask

  task automatic sendBit(input logic b);
    sda_m = b;
    waitClk(4);
    scl = 1'b1;
    waitClk(8);
    scl = 1'b0;
    waitClk(4);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  // Ninth clock: master releases SDA, target ACK sampled mid high phase.
  task automatic ackBit(input logic expOe, input string tag);
    sda_m = 1'b1;
    waitClk(4);
    scl = 1'b1;
    waitClk(4);
    @(negedge clk);
    checkOutput(tag, {31'h0, sda_oe}, {31'h0, expOe});
    waitClk(4);
    scl = 1'b0;
    waitClk(4);
  endtask

  // Full transfer: START, address byte, nBytes bytes from payload (MSB
  // byte first), STOP. ack says whether the target should accept it.
  task automatic applyStimulus(input logic [7:0] addrByte, input int nBytes,
                               input logic [31:0] payload, input logic ack);
    logic [7:0] b;
    busStart();
    sendByte(addrByte);
    ackBit(ack, "addr_ack");
    for (int k = 0; k < nBytes; k++) begin
      b = payload[31-8*k -: 8];
      if (ack) expQ.push_back(b);
      sendByte(b);
      if (k == 0) checkOutput("addressed_during", {31'h0, addressed}, {31'h0, ack});
      ackBit(ack, "data_ack");
    end
    busStop();
    waitClk(4);
    checkOutput("addressed_after_stop", {31'h0, addressed}, 32'h0);
  endtask

  initial begin
    int s0;
    int p0;
    int v0;
    bit seen;

    rst   = 1'b0;
    scl   = 1'b1;
    sda_m = 1'b1;
    waitClk(5);
    @(negedge clk);
    checkOutput("rst_sda_oe",     {31'h0, sda_oe},     32'h0);
    checkOutput("rst_data_out",   {24'h0, data_out},   32'h0);
    checkOutput("rst_data_valid", {31'h0, data_valid}, 32'h0);
    checkOutput("rst_addressed",  {31'h0, addressed},  32'h0);
    checkOutput("rst_start_det",  {31'h0, start_det},  32'h0);
    checkOutput("rst_stop_det",   {31'h0, stop_det},   32'h0);
    rst = 1'b1;
    waitClk(10);

    // Single byte write to 0x50.
    s0 = nStart; p0 = nStop; v0 = nValid;
    applyStimulus(8'hA0, 1, 32'hA500_0000, 1'b1);
    waitClk(8);
    checkOutput("t1_valid_cnt", nValid - v0, 1);
    checkOutput("t1_start_cnt", nStart - s0, 1);
    checkOutput("t1_stop_cnt",  nStop - p0,  1);
    checkOutput("t1_data_out",  {24'h0, data_out}, 32'hA5);

    // Foreign address 0x51: no ACK anywhere, no data.
    s0 = nStart; p0 = nStop; v0 = nValid;
    applyStimulus(8'hA2, 1, 32'hA500_0000, 1'b0);
    waitClk(8);
    checkOutput("t2_valid_cnt", nValid - v0, 0);
    checkOutput("t2_stop_cnt",  nStop - p0,  1);

    // Read request to 0x50: NACKed, target ignores the following clocks.
    v0 = nValid;
    applyStimulus(8'hA1, 1, 32'h5A00_0000, 1'b0);
    waitClk(8);
    checkOutput("t3_valid_cnt", nValid - v0, 0);

    // Multi-byte write.
    v0 = nValid;
    applyStimulus(8'hA0, 3, 32'h1234_FF00, 1'b1);
    waitClk(8);
    checkOutput("t4_valid_cnt", nValid - v0, 3);
    checkOutput("t4_data_out",  {24'h0, data_out}, 32'hFF);

    // Repeated START after a partial byte.
    s0 = nStart; v0 = nValid;
    busStart();
    sendByte(8'hA0);
    ackBit(1'b1, "t5_addr_ack");
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
    checkOutput("t5_addressed_pre", {31'h0, addressed}, 32'h1);
    busStart();
    checkOutput("t5_addressed_rs", {31'h0, addressed}, 32'h0);
    sendByte(8'hA0);
    ackBit(1'b1, "t5_addr_ack2");
    expQ.push_back(8'h3C);
    sendByte(8'h3C);
    ackBit(1'b1, "t5_data_ack");
    busStop();
    waitClk(8);
    checkOutput("t5_start_cnt", nStart - s0, 2);
    checkOutput("t5_valid_cnt", nValid - v0, 1);
    checkOutput("t5_data_out",  {24'h0, data_out}, 32'h3C);

    // Reset while the target drives the address ACK.
    busStart();
    sendByte(8'hA0);
    sda_m = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sda_oe) seen = 1'b1;
    end
    checkOutput("t6_oe_seen", {31'h0, seen}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t6_oe_async",   {31'h0, sda_oe},   32'h0);
    checkOutput("t6_data_out_rst", {24'h0, data_out}, 32'h0);
    scl   = 1'b1;
    sda_m = 1'b1;
    waitClk(4);
    @(negedge clk);
    rst = 1'b1;
    waitClk(8);
    v0 = nValid;
    applyStimulus(8'hA0, 1, 32'h7700_0000, 1'b1);
    waitClk(8);
    checkOutput("t6_valid_cnt", nValid - v0, 1);
    checkOutput("t6_data_out",  {24'h0, data_out}, 32'h77);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_write_rx.md
Name: i2c_slave_write_rx

Overview:
- I2C target (slave) receiver for write transfers: the responder end of the team's I2C master write path.
- Oversamples the SCL and SDA lines on the system clock and detects START and STOP conditions.
- Matches the 7-bit address, ACKs by pulling SDA low through an open-drain enable, and delivers each received data byte on a one-cycle valid strobe.
- Sits on the shared wired-AND SDA net beside the master; its sda_oe is ORed into the line pull-down.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- scl  input  1  I2C clock line as seen on the bus.
- sda  input  1  I2C data line as seen on the bus (resolved wired-AND value).
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- data_out  output  8  last received data byte, MSB first on the wire.
- data_valid  output  1  one-clk pulse when data_out is updated.
- addressed  output  1  high from address-ACK until STOP or repeated START.
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.

Behaviour:
- Reset (rst=0, asynchronous):
  - sda_oe=0, data_out=8'h00, data_valid=0, addressed=0, start_det=0, stop_det=0.
  - State=IDLE; synchroniser flops reset to 1 (idle bus).
- Input conditioning:
  - scl_s and sda_s are SYNC_STAGES-deep synchronised copies; scl_d and sda_d are their one-cycle-delayed copies.
  - scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
  - START = sda_s falling while scl_s and scl_d are both 1.
  - STOP = sda_s rising while scl_s and scl_d are both 1.
- Timing requirement: SCL high and low phases must each be at least SYNC_STAGES+2 clk cycles.
- START/STOP priority:
  - START in any state: enter ADDR, clear the bit counter, drop addressed, release sda_oe, pulse start_det. This is the repeated-START case.
  - STOP in any state: enter IDLE, release sda_oe, drop addressed, pulse stop_det. Any partial byte is discarded and data_valid is not pulsed.
- States:
  - IDLE: wait for START.
  - ADDR: shift sda_s into an 8-bit shift register on each scl_rise, MSB first, 3-bit bit counter. After the 8th rise: if shift[7:1]==SLAVE_ADDR and shift[0]==0 (write), go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: on the first scl_fall, set sda_oe=1. Hold through the 9th scl_rise. On the following scl_fall, set sda_oe=0, set addressed=1, and go to DATA.
  - DATA: shift 8 bits as in ADDR. On the 8th scl_rise, load data_out and go to DATA_ACK; data_valid pulses in the clk cycle after that scl_rise (1-cycle latency).
  - DATA_ACK: same ACK sequence as ADDR_ACK, then return to DATA, so multi-byte writes continue until STOP.
  - IGNORE: sda_oe held at 0 (NACK). Ignore SCL until the next START or STOP.
- Read requests (R/W=1) are not supported and are NACKed through IGNORE.
- Any other scl_rise or scl_fall not listed above leaves the state unchanged.
- sda_oe is driven only in the ACK states. It is never asserted while SCL is high, except when held across the 9th clock.
- When start_det/stop_det and data_valid would coincide, START/STOP handling wins and data_valid is suppressed.

Test Plan:
- Write to 0x50 with data 0xA5, then STOP -> sda_oe high across the 9th and 18th SCL pulses; data_out=8'hA5; data_valid pulses exactly once; start_det and stop_det each pulse once; addressed drops at STOP.
- Address 0x51 write, data 0xA5 -> sda_oe stays 0 for the whole transfer; no data_valid; addressed stays 0.
- Address 0x50 with R/W=1 -> NACK (sda_oe 0 on the 9th clock); state IGNORE until STOP.
- Write to 0x50 with bytes 0x12, 0x34, 0xFF, then STOP -> three data_valid pulses carrying 0x12, 0x34, 0xFF; an ACK after each byte.
- Repeated START after 4 data bits, then a new 0x50 write of 0x3C -> start_det pulses twice; no valid for the partial byte; data_out=8'h3C.
- Assert rst=0 during the ADDR_ACK low phase -> sda_oe=0 in the same cycle, asynchronously. After release, the next write to 0x50 of 0x77 is received correctly.
